// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// flow control, hazard stall, branch flush (bubble insertion) and an
// optional 2-entry skid buffer (SKID=1) that decouples in_ready from
// out_ready.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall, bubble
// and flush performance counters together with the CNT_W parameter.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        SKID    = 1,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned      CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // State value equals the number of held entries (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_s;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   main_s;
  logic [DATA_W-1:0]   skid_r;
  logic [DATA_W-1:0]   skid_s;
  logic                out_valid_r;
  logic                in_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

  // Acceptance: skid mode looks only at registered occupancy, bypass mode
  // lets a consuming downstream free the single slot in the same cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID != 0) begin
      in_ready_s = rst_n & ~flush & ~stall & (state_r != ST_TWO);
    end else begin
      in_ready_s = rst_n & ~flush & ~stall & (~out_valid_r | out_ready);
    end
    in_xfer_s  = in_valid & in_ready_s;
    out_xfer_s = out_valid_r & out_ready;
  end

  // Next-state and datapath selection; FIFO order keeps skid older than input.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          main_s  = in_data;
          state_s = ST_ONE;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          main_s  = in_data;
          state_s = ST_ONE;
        end else if (in_xfer_s) begin
          // Only reachable with SKID=1: downstream stalled, park new word.
          skid_s  = in_data;
          state_s = ST_TWO;
        end else if (out_xfer_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_xfer_s) begin
          main_s  = skid_r;
          state_s = ST_ONE;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // State and payload registers: reset > flush > normal update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= NOP_VAL;
      skid_r      <= NOP_VAL;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      main_r      <= NOP_VAL;
      skid_r      <= NOP_VAL;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      out_valid_r <= (state_s != ST_EMPTY);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;

  // Performance counters; cleared only by reset, never by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r  <= sat_inc(stall_cnt_r, out_valid_r & ~out_ready);
      bubble_cnt_r <= sat_inc(bubble_cnt_r, out_ready & ~out_valid_r);
      flush_cnt_r  <= sat_inc(flush_cnt_r, flush & (state_r != ST_EMPTY));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: instance "a" uses SKID=1, instance "b"
// uses SKID=0 and is exercised against a queue scoreboard.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] a_stall_cnt, a_bubble_cnt, a_flush_cnt;
  logic [15:0] b_stall_cnt, b_bubble_cnt, b_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .NOP_VAL(32'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .NOP_VAL(32'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_w;
    int          sent;
    int          rcvd;
    logic        acc;

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    a_in_valid = 1'b0; a_in_data = 32'd0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 32'd0; b_out_ready = 1'b0;

    // 1 reset
    tick(); tick();
    check("rst_a_valid", a_out_valid, 32'd0);
    check("rst_a_data", a_out_data, 32'd0);
    check("rst_a_occ", a_occ, 32'd0);
    check("rst_a_ready", a_in_ready, 32'd0);
    check("rst_b_ready", b_in_ready, 32'd0);
    check("rst_b_valid", b_out_valid, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("rst_flush_cnt", a_flush_cnt, 32'd0);
    check("rst_stall_cnt", a_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // 2 stream 1..8 with out_ready high
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'(i);
      #1 check("stream_ready", a_in_ready, 32'd1);
      tick();
      check("stream_valid", a_out_valid, 32'd1);
      check("stream_data", a_out_data, 32'(i));
      check("stream_occ", a_occ, 32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drain", a_out_valid, 32'd0);

    // 3 backpressure into skid
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hA; tick();
    a_in_data = 32'hB; tick();
    check("bp_occ2", a_occ, 32'd2);
    a_in_data = 32'hC;
    #1 check("bp_ready0", a_in_ready, 32'd0);
    tick();
    check("bp_hold_occ", a_occ, 32'd2);
    check("bp_data_a", a_out_data, 32'hA);
    a_out_ready = 1'b1; tick();
    check("bp_data_b", a_out_data, 32'hB);
    check("bp_occ1", a_occ, 32'd1);
    tick();
    check("bp_data_c", a_out_data, 32'hC);
    a_in_valid = 1'b0; tick();
    check("bp_empty", a_out_valid, 32'd0);
    check("bp_hold_c", a_out_data, 32'hC);

    // 4 flush with full skid and a simultaneous input
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h11; tick();
    a_in_data = 32'h22; tick();
    check("fl_occ2", a_occ, 32'd2);
    flush = 1'b1; a_in_data = 32'h33;
    #1 check("fl_ready0", a_in_ready, 32'd0);
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    check("fl_valid", a_out_valid, 32'd0);
    check("fl_occ", a_occ, 32'd0);
    check("fl_data", a_out_data, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("fl_cnt", a_flush_cnt, 32'd1);
`endif
    a_out_ready = 1'b1; tick(); tick();
    check("fl_no33", a_out_valid, 32'd0);

    // 5 stall: drain continues, acceptance blocked
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h55; tick();
    stall = 1'b1; a_in_data = 32'h66; a_out_ready = 1'b1;
    #1 check("st_ready0", a_in_ready, 32'd0);
    tick();
    check("st_drained", a_occ, 32'd0);
    check("st_hold", a_out_data, 32'h55);
    check("st_ready1", a_in_ready, 32'd0);
    tick();
    check("st_ready2", a_in_ready, 32'd0);
    tick();
    stall = 1'b0;
    #1 check("st_release", a_in_ready, 32'd1);
    tick();
    check("st_valid", a_out_valid, 32'd1);
    check("st_data", a_out_data, 32'h66);

    // reset mid-transfer discards everything
    a_in_data = 32'h77; a_out_ready = 1'b0; rst_n = 1'b0;
    tick();
    check("rst_mid_occ", a_occ, 32'd0);
    check("rst_mid_data", a_out_data, 32'd0);
    rst_n = 1'b1; a_in_valid = 1'b0;

    // 6 SKID=0: same-cycle backpressure, then toggled out_ready scoreboard
    b_in_valid = 1'b1; b_in_data = 32'h77; b_out_ready = 1'b0; tick();
    check("b_full", b_out_valid, 32'd1);
    b_in_data = 32'h78;
    #1 check("b_ready0", b_in_ready, 32'd0);
    b_out_ready = 1'b1;
    #1 check("b_ready1", b_in_ready, 32'd1);
    b_in_valid = 1'b0; tick();
    check("b_drain", b_out_valid, 32'd0);

    sent = 0; rcvd = 0;
    b_in_data = $urandom;
    for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
      b_out_ready = ~b_out_ready;
      b_in_valid = (sent < 100);
      #1;
      if (b_out_valid && b_out_ready) begin
        check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          exp_w = q.pop_front();
          check("sb_data", b_out_data, exp_w);
        end
        rcvd++;
      end
      acc = b_in_valid && b_in_ready;
      if (acc) begin
        q.push_back(b_in_data);
        sent++;
      end
      tick();
      if (acc) b_in_data = $urandom;
    end
    b_in_valid = 1'b0;
    check("sb_sent", 32'(sent), 32'd100);
    check("sb_rcvd", 32'(rcvd), 32'd100);
    check("sb_left", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
